// File: rtl/dot_product_pkg.sv
// Shared constants and types for the dotProduct_macro initiator.
package dot_product_pkg;

  localparam int N_DEF       = 8;
  localparam int W_DEF       = 8;
  localparam int RW_DEF      = 2 * W_DEF + $clog2(N_DEF);
  localparam int TIMEOUT_DEF = 1024;

  // Counter/address width that never collapses to zero bits.
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int AW_DEF = cw(2 * N_DEF);
  localparam int BW_DEF = cw(W_DEF);
  localparam int TW_DEF = cw(TIMEOUT_DEF);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SHIFT     = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dp_vec_store.sv
// 2N x W element store: X in the low half, Y in the high half.
module dp_vec_store #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  // Element writes; the whole store clears on reset.
  always_ff @(posedge clk) begin
    if (Reset)   mem_q        <= '0;
    else if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dot_product_driver.sv
// Initiator for dotProduct_macro: streams X then Y serially, waits for Done.
module dot_product_driver
  import dot_product_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 wr_en,
  input  logic [cw(2*N)-1:0]   wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 go,
  output logic                 busy,
  output logic                 SerialData,
  output logic                 Start,
  input  logic [RW-1:0]        DataOut,
  input  logic                 Done,
  output logic [RW-1:0]        result,
  output logic                 result_valid,
  output logic                 timeout
);

  localparam int AW = cw(2 * N);
  localparam int BW = cw(W);
  localparam int TW = cw(TIMEOUT);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q;
  logic [AW-1:0] elem_cnt_q;
  logic [W-1:0]  shreg_q;
  logic [TW-1:0] tmr_q;
  logic [RW-1:0] result_q;
  logic          rv_q, to_q;

  logic          st_we;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          bit_last, elem_last, tmr_exp;

  // Stores only change in IDLE, so the stream is stable for a whole frame.
  assign st_we     = wr_en && (state_q == IDLE) &&
                     ({1'b0, wr_addr} < (AW+1)'(2 * N));
  // START preloads element 0; during SHIFT look one element ahead.
  assign rd_addr   = (state_q == START) ? '0 : elem_cnt_q + AW'(1);
  assign bit_last  = (bit_cnt_q == BW'(W - 1));
  assign elem_last = (elem_cnt_q == AW'(2 * N - 1));
  assign tmr_exp   = (tmr_q == TW'(TIMEOUT - 1));

  dp_vec_store #(.DEPTH(2 * N), .W(W), .AW(AW)) u_store (
    .clk   (clk),
    .Reset (Reset),
    .we    (st_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: Done takes priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go) state_d = START;
      START:     state_d = SHIFT;
      SHIFT:     if (bit_last && elem_last) state_d = WAIT_DONE;
      WAIT_DONE: if (Done || tmr_exp) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Shift register, counters, timeout timer and result capture.
  always_ff @(posedge clk) begin
    if (Reset) begin
      bit_cnt_q  <= '0;
      elem_cnt_q <= '0;
      shreg_q    <= '0;
      tmr_q      <= '0;
      result_q   <= '0;
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      rv_q  <= 1'b0;
      to_q  <= 1'b0;
      tmr_q <= '0;
      case (state_q)
        START: begin
          shreg_q    <= rd_data;
          bit_cnt_q  <= '0;
          elem_cnt_q <= '0;
        end
        SHIFT: begin
          if (bit_last) begin
            bit_cnt_q  <= '0;
            elem_cnt_q <= elem_cnt_q + AW'(1);
            shreg_q    <= rd_data;
          end else begin
            bit_cnt_q  <= bit_cnt_q + BW'(1);
            shreg_q    <= shreg_q >> 1;
          end
        end
        WAIT_DONE: begin
          if (Done) begin
            result_q <= DataOut;
            rv_q     <= 1'b1;
          end else if (tmr_exp) begin
            to_q     <= 1'b1;
          end else begin
            tmr_q    <= tmr_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; serial line is quiet outside SHIFT.
  always_comb begin
    busy       = (state_q != IDLE);
    Start      = (state_q == START);
    SerialData = (state_q == SHIFT) && shreg_q[0];
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_dot_product_driver.sv
// Scoreboard bench for dot_product_driver with a scripted Done responder.
module tb_dot_product_driver;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int RW = 19;
  localparam int TO = 1024;
  localparam int SB = 2 * N * W;
  localparam int AW = 4;

  typedef struct {
    int          start_cyc;
    int          nbits;
    logic [SB-1:0] bits;
  } frame_t;

  typedef struct {
    bit          is_to;
    logic [RW-1:0] val;
    int          cyc;
  } ev_t;

  logic          clk = 1'b0, Reset = 1'b1, wr_en = 1'b0, go = 1'b0, Done = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [RW-1:0] DataOut = '0;
  logic          busy, SerialData, Start, result_valid, timeout;
  logic [RW-1:0] result;

  int cyc = 0, n_chk = 0, n_err = 0;
  bit mon_en = 1'b0;

  frame_t exp_fq[$];
  ev_t    exp_eq[$];
  logic [W-1:0] sx[N] = '{default: '0};
  logic [W-1:0] sy[N] = '{default: '0};

  dot_product_driver dut (
    .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .busy(busy), .SerialData(SerialData),
    .Start(Start), .DataOut(DataOut), .Done(Done), .result(result),
    .result_valid(result_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish by 300000ns");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic frame_t mk_frame(input int sc, input int nb);
    frame_t f;
    logic [W-1:0] v;
    f.start_cyc = sc;
    f.nbits     = nb;
    f.bits      = '0;
    for (int k = 0; k < nb; k++) begin
      v = (k / W < N) ? sx[k / W] : sy[k / W - N];
      f.bits[k] = v[k % W];
    end
    return f;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_xfer(output int c0, input int nb);
    c0 = cyc;
    go = 1'b1;
    exp_fq.push_back(mk_frame(c0 + 1, nb));
    @(negedge clk);
    go = 1'b0;
  endtask

  // Done arrives 'dly' cycles after WAIT_DONE is entered at c0+130.
  task automatic respond(input int c0, input int dly, input int val);
    ev_t e;
    wait_until(c0 + 2 * SB / 2 + 2 + dly);
    e.is_to = 1'b0; e.val = RW'(val); e.cyc = cyc + 1;
    exp_eq.push_back(e);
    Done = 1'b1; DataOut = RW'(val);
    @(negedge clk);
    Done = 1'b0; DataOut = '0;
  endtask

  // Monitor: frame capture and result/timeout event checking.
  frame_t        cur;
  ev_t           ev;
  logic [SB-1:0] cap_bits = '0, last_frame = '0;
  int            cap_n = 0;
  bit            cap_on = 1'b0, post_chk = 1'b0;

  always @(negedge clk) if (mon_en) begin
    if (cap_on) begin
      cap_bits[cap_n] = SerialData;
      cap_n++;
      chk("start_one_cycle", Start, 0);
      chk("busy_in_shift", busy, 1);
      if (cap_n == cur.nbits) begin
        n_chk++;
        if (cap_bits !== cur.bits) begin
          n_err++;
          $display("FAIL frame_bits: got %h expected %h", cap_bits, cur.bits);
        end
        last_frame = cap_bits;
        cap_on     = 1'b0;
        post_chk   = (cur.nbits < SB);
      end
    end else if (post_chk) begin
      chk("after_reset_outputs", {busy, Start, SerialData}, 0);
      post_chk = 1'b0;
    end else if (Start) begin
      if (exp_fq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_start: got Start=1 expected none (cycle %0d)", cyc);
      end else begin
        cur = exp_fq.pop_front();
        chk("start_cycle", cyc, cur.start_cyc);
        chk("serial_at_start", SerialData, 0);
        cap_on   = 1'b1;
        cap_n    = 0;
        cap_bits = '0;
      end
    end else begin
      chk("idle_serial", SerialData, 0);
    end

    if (result_valid || timeout) begin
      if (exp_eq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_event: got rv=%0d to=%0d expected none (cycle %0d)",
                 result_valid, timeout, cyc);
      end else begin
        ev = exp_eq.pop_front();
        chk("event_timeout", timeout, ev.is_to);
        chk("event_rv", result_valid, !ev.is_to);
        chk("event_cycle", cyc, ev.cyc);
        chk("event_result", result, ev.val);
        chk("busy_drop", busy, 0);
      end
    end
  end

  initial begin
    int c0, c1;
    ev_t e;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    chk("reset_state", {busy, Start, SerialData, result_valid, timeout, result}, 0);
    mon_en = 1'b1;

    // T1: X[i]=i+1, Y[i]=1 -> 36
    for (int i = 0; i < N; i++) begin
      wr(i, i + 1);  sx[i] = W'(i + 1);
      wr(N + i, 1);  sy[i] = 8'd1;
    end
    start_xfer(c0, SB);
    respond(c0, 0, 36);
    wait_until(c0 + 134);
    chk("t1_x0_bits", last_frame[7:0], 8'h01);
    chk("t1_x1_bits", last_frame[15:8], 8'h02);
    chk("t1_result", result, 36);

    // T2: all 255 -> 520200
    for (int i = 0; i < 2 * N; i++) wr(i, 255);
    for (int i = 0; i < N; i++) begin sx[i] = 8'hFF; sy[i] = 8'hFF; end
    start_xfer(c0, SB);
    respond(c0, 1, 520200);
    wait_until(c0 + 134);
    chk("t2_result", result, 520200);

    // T3: no Done -> timeout at c0+1154, result held
    start_xfer(c0, SB);
    e.is_to = 1'b1; e.val = RW'(520200); e.cyc = c0 + 130 + TO;
    exp_eq.push_back(e);
    wait_until(c0 + 130 + TO + 2);
    chk("t3_busy", busy, 0);
    chk("t3_result_kept", result, 520200);

    // T4: reset at cycle 50 of a transfer -> 49 bits then idle, stores cleared
    start_xfer(c0, 49);
    wait_until(c0 + 50);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("t4_result_cleared", result, 0);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < N; i++) begin sx[i] = '0; sy[i] = '0; end
    start_xfer(c0, SB);
    respond(c0, 2, 0);
    wait_until(c0 + 134);
    chk("t4_zero_frame", last_frame, 0);

    // T5: write/go/Done during SHIFT are all ignored
    wr(0, 5);  sx[0] = 8'd5;
    wr(N, 3);  sy[0] = 8'd3;
    start_xfer(c0, SB);
    wait_until(c0 + 20);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'd7;
    go = 1'b1; Done = 1'b1; DataOut = RW'(999);
    @(negedge clk);
    wr_en = 1'b0; go = 1'b0; Done = 1'b0; DataOut = '0;
    respond(c0, 3, 15);

    // T6: go and write X[3]=200 in the cycle result_valid pulses
    chk("t6_rv_cycle", result_valid, 1);
    sx[3] = 8'd200;
    c1 = cyc;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'd200; go = 1'b1;
    exp_fq.push_back(mk_frame(c1 + 1, SB));
    @(negedge clk);
    wr_en = 1'b0; go = 1'b0;
    respond(c1, 0, 15);
    wait_until(c1 + 134);
    chk("t6_x3_bits", last_frame[31:24], 200);
    chk("t6_x0_old", last_frame[7:0], 5);
    chk("t6_result", result, 15);

    repeat (4) @(negedge clk);
    chk("frames_left", exp_fq.size(), 0);
    chk("events_left", exp_eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dot_product_driver.md
Name: dot_product_driver

Overview:
- Initiator side of the dotProduct_macro serial interface.
- Holds two N-element unsigned vectors (X, Y), loaded through a parallel write port.
- On command, issues a one-cycle Start and shifts both vectors out on SerialData, then waits for Done and captures DataOut as the result.
- Sits between host/control logic and dotProduct_macro; replaces the hand-written stimulus used at top level.

Parameters:
- N, 8, elements per vector.
- W, 8, bits per element.
- RW, 19, result width (2*W + clog2(N)).
- TIMEOUT, 1024, max cycles spent in WAIT_DONE before abort.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- wr_en  in  1  element write strobe.
- wr_addr  in  clog2(2N)  0..N-1 selects X[i], N..2N-1 selects Y[i-N].
- wr_data  in  W  element value.
- go  in  1  start-transfer request (level sampled).
- busy  out  1  high in every state except IDLE.
- SerialData  out  1  serial bit stream to the dotProduct_macro unit.
- Start  out  1  one-cycle frame start to the dotProduct_macro unit.
- DataOut  in  RW  result from the dotProduct_macro unit.
- Done  in  1  result-valid from the dotProduct_macro unit.
- result  out  RW  captured DataOut.
- result_valid  out  1  one-cycle pulse when result updates.
- timeout  out  1  one-cycle pulse on WAIT_DONE abort.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; result=0; both vector stores cleared to 0; counters 0. Reset overrides all other inputs in that cycle, including mid-operation.
- FSM states: IDLE, START, SHIFT, WAIT_DONE.
- IDLE -> START when go=1. START lasts 1 cycle with Start=1 and SerialData=0.
- START -> SHIFT. SHIFT lasts exactly 2*N*W cycles.
- Stream order in SHIFT: X[0]..X[N-1], then Y[0]..Y[N-1]; each element LSB first. Bit k of the stream is driven k+1 cycles after Start.
- SHIFT -> WAIT_DONE after the last bit. SerialData=0 outside SHIFT.
- WAIT_DONE: on Done=1, register DataOut into result; pulse result_valid the next cycle; return to IDLE.
- WAIT_DONE abort: after TIMEOUT cycles with no Done, pulse timeout, leave result unchanged, return to IDLE.
- Timing with go sampled at cycle 0:
  - Start=1 at cycle 1.
  - Bits at cycles 2..2NW+1.
  - WAIT_DONE entered at cycle 2NW+2.
  - Done at cycle d gives result_valid at d+1.
  - Timeout pulses at cycle 2NW+2+TIMEOUT.
- Writes: accepted only in IDLE. A write in the same cycle as go is accepted and its value is transmitted. Writes while busy=1 are dropped. Out-of-range wr_addr is dropped.
- go while busy=1: ignored; not queued.
- Done outside WAIT_DONE: ignored.
- Done and timeout expiry in the same cycle: Done wins, no timeout pulse.
- busy drops in the same cycle result_valid or timeout pulses. A new go is accepted in that cycle.
- Element read-out uses a W-bit shift register reloaded from the store at each element boundary. Bit counter is clog2(W) bits; element counter is clog2(2N) bits.

Decomposition:
- Shared package dot_product_pkg:
  - Constants N, W, RW, TIMEOUT defaults.
  - State enum {IDLE, START, SHIFT, WAIT_DONE}.
  - Address-width and counter-width constants.
- One sub-module: dp_vec_store, a 2N x W register file.
  - Synchronous write, combinational read, synchronous clear on Reset.
  - Instantiated once; the driver holds the FSM, counters and shift register.

Test Plan:
1. Load X[i]=i+1, Y[i]=1; go at cycle 0 -> Start=1 only at cycle 1; cycles 2..9 SerialData=1,0,0,0,0,0,0,0. Bench responder returns DataOut=36 with Done -> result=36, one-cycle result_valid.
2. All elements 255 -> 128 consecutive 1 bits at cycles 2..129. Responder returns 520200 -> result=520200, no timeout.
3. Responder never asserts Done -> timeout pulse at cycle 1154 (130+1024), busy=0, result keeps its previous value.
4. Reset asserted at cycle 50 during SHIFT -> next cycle Start=0, SerialData=0, busy=0. A following go with no writes -> 128 zero bits.
5. During SHIFT: wr_en to X[0]=7, go=1, and spurious Done=1 -> all ignored; stream and result unchanged; a later transfer still sends the old X[0].
6. In IDLE, wr_en X[3]=200 in the same cycle as go -> element X[3] bits (cycles 26..33) = 0,0,0,1,0,0,1,1.
